// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key decoder: receive FSM states,
// prefix and game-key scan codes, key indices and the (ext, code) lookup.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam int unsigned NUM_KEYS  = 4;
  localparam int unsigned KEY_IDX_W = 2;
  localparam int unsigned BYTE_W    = 8;

  localparam logic [BYTE_W-1:0] CODE_E0    = 8'hE0;
  localparam logic [BYTE_W-1:0] CODE_F0    = 8'hF0;
  localparam logic [BYTE_W-1:0] CODE_LEFT  = 8'h6B;
  localparam logic [BYTE_W-1:0] CODE_RIGHT = 8'h74;
  localparam logic [BYTE_W-1:0] CODE_JUMP  = 8'h12;
  localparam logic [BYTE_W-1:0] CODE_SHOOT = 8'h1A;

  localparam logic [KEY_IDX_W-1:0] KEY_LEFT  = 2'd0;
  localparam logic [KEY_IDX_W-1:0] KEY_RIGHT = 2'd1;
  localparam logic [KEY_IDX_W-1:0] KEY_JUMP  = 2'd2;
  localparam logic [KEY_IDX_W-1:0] KEY_SHOOT = 2'd3;

  typedef struct packed {
    logic                 hit;
    logic [KEY_IDX_W-1:0] idx;
  } key_lookup_t;

  // Left/right only match with the E0 prefix; jump/shoot only without it.
  function automatic key_lookup_t key_lookup(input logic ext, input logic [BYTE_W-1:0] code);
    key_lookup_t r;
    r = '0;
    case ({ext, code})
      {1'b1, CODE_LEFT}:  begin r.hit = 1'b1; r.idx = KEY_LEFT;  end
      {1'b1, CODE_RIGHT}: begin r.hit = 1'b1; r.idx = KEY_RIGHT; end
      {1'b0, CODE_JUMP}:  begin r.hit = 1'b1; r.idx = KEY_JUMP;  end
      {1'b0, CODE_SHOOT}: begin r.hit = 1'b1; r.idx = KEY_SHOOT; end
      default:            r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, 11-bit frame
// FSM with odd-parity/stop check. Optional watchdog under PS2_WATCHDOG_EN.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic [BYTE_W-1:0] byte_c,
  output logic              valid_c,
  output logic              err_c
);

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("ps2_frame_rx: SYNC_STAGES and TIMEOUT_CYCLES must both be >= 2");
  end

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  rx_state_e              state_q, state_d;
  logic [BYTE_W-1:0]      shift_q, shift_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   par_q, par_d;
  logic                   clk_s, data_s, fall;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;
  assign byte_c = shift_q;

  // Synchronizers reset to the idle-high line level so reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_s;
    end
  end

`ifdef PS2_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_expired;

  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d = wd_q;
    if (fall) begin
      wd_d = '0;
    end else if (state_q != IDLE && !wd_expired) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    valid_c = 1'b0;
    err_c   = 1'b0;
    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d = {data_s, shift_q[BYTE_W-1:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_s && (^{shift_q, par_q})) valid_c = 1'b1;
          else                               err_c   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef PS2_WATCHDOG_EN
    else if (state_q != IDLE && wd_expired) begin
      state_d = IDLE;
      err_c   = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/ps2_keys.sv
// PS/2 keyboard to held-key levels: E0/F0 prefix tracking and game-key lookup
// on top of ps2_frame_rx. Watchdog compiled in with PS2_WATCHDOG_EN.
module ps2_keys
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [NUM_KEYS-1:0] keys,
  output logic [BYTE_W-1:0]   scan_code,
  output logic                scan_valid,
  output logic                frame_err
);

  logic [BYTE_W-1:0]   rx_byte_c;
  logic                rx_valid_c, rx_err_c;
  key_lookup_t         lk_c;

  logic [NUM_KEYS-1:0] keys_q, keys_d;
  logic [BYTE_W-1:0]   scan_code_q, scan_code_d;
  logic                scan_valid_q, scan_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                ext_q, ext_d, brk_q, brk_d;

  ps2_frame_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .byte_c   (rx_byte_c),
    .valid_c  (rx_valid_c),
    .err_c    (rx_err_c)
  );

  assign lk_c = key_lookup(ext_q, rx_byte_c);

  always_comb begin
    keys_d       = keys_q;
    scan_code_d  = scan_code_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    scan_valid_d = rx_valid_c;
    frame_err_d  = rx_err_c;
    if (rx_err_c) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid_c) begin
      scan_code_d = rx_byte_c;
      if (rx_byte_c == CODE_E0) begin
        ext_d = 1'b1;
      end else if (rx_byte_c == CODE_F0) begin
        brk_d = 1'b1;
      end else begin
        if (lk_c.hit) keys_d[lk_c.idx] = ~brk_q;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_q       <= '0;
      scan_code_q  <= '0;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
    end else begin
      keys_q       <= keys_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
    end
  end

  assign keys       = keys_q;
  assign scan_code  = scan_code_q;
  assign scan_valid = scan_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_keys.sv
// Directed bench for ps2_keys: bit-banged PS/2 frames with hand-computed
// expected key levels, scan codes, pulse counts and output latency.
module tb_ps2_keys;

`ifdef PS2_WATCHDOG_EN
  localparam int unsigned TO_CYC = 50;
`else
  localparam int unsigned TO_CYC = 100000;
`endif
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] keys;
  logic [7:0] scan_code;
  logic       scan_valid, frame_err;

  int errors = 0;
  int checks = 0;
  int nv = 0, ne = 0;
  int v0, e0;
  logic lat_early, lat_hit;

  ps2_keys #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .keys       (keys),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (scan_valid) nv++;
    if (frame_err)  ne++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends the first nbits of a frame; records output pulses around the stop edge.
  task automatic send_bits(input logic [7:0] b, input logic par_flip,
                           input logic stop_v, input int nbits);
    logic [10:0] f;
    f = {stop_v, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        repeat (2) @(negedge clk);
        lat_early = scan_valid | frame_err;
        @(negedge clk);
        lat_hit = scan_valid | frame_err;
        repeat (HALF - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(b, 1'b0, 1'b1, 11);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check("rst_keys", 32'(keys), 32'h0);
    check("rst_scan_code", 32'(scan_code), 32'h0);
    check("rst_scan_valid", 32'(scan_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    check("idle_keys", 32'(keys), 32'h0);
    check("idle_valid_cnt", 32'(nv), 32'h0);
    check("idle_err_cnt", 32'(ne), 32'h0);

    // Press jump, then right, then release jump.
    v0 = nv;
    send(8'h12);
    check("jump_keys", 32'(keys), 32'b0100);
    check("jump_scan_code", 32'(scan_code), 32'h12);
    check("jump_valid_cnt", 32'(nv - v0), 32'd1);
    check("lat_early", 32'(lat_early), 32'h0);
    check("lat_hit", 32'(lat_hit), 32'h1);
    send(8'hE0);
    check("e0_scan_code", 32'(scan_code), 32'hE0);
    check("e0_keys", 32'(keys), 32'b0100);
    send(8'h74);
    check("right_keys", 32'(keys), 32'b0110);
    check("right_valid_cnt", 32'(nv - v0), 32'd3);
    send(8'hF0);
    send(8'h12);
    check("jump_rel_keys", 32'(keys), 32'b0010);
    check("jump_rel_valid_cnt", 32'(nv - v0), 32'd5);

    // Typematic left, then extended release, then keypad-4 no-op.
    for (int r = 0; r < 3; r++) begin
      send(8'hE0);
      send(8'h6B);
      check("left_typematic", 32'(keys), 32'b0011);
    end
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    check("left_rel_keys", 32'(keys), 32'b0010);
    send(8'hF0);
    send(8'hE0);
    send(8'h74);
    check("right_rel_f0e0_keys", 32'(keys), 32'b0000);
    send(8'hE0);
    send(8'h74);
    check("right_press_again", 32'(keys), 32'b0010);
    send(8'h6B);
    check("kp4_keys", 32'(keys), 32'b0010);
    check("kp4_scan_code", 32'(scan_code), 32'h6B);
    send(8'hF0);
    send(8'h1A);
    check("stray_break_keys", 32'(keys), 32'b0010);

    // Bad parity and bad stop: errors only, nothing else changes.
    e0 = ne;
    v0 = nv;
    send_bits(8'h1A, 1'b1, 1'b1, 11);
    check("badpar_err_cnt", 32'(ne - e0), 32'd1);
    check("badpar_lat_hit", 32'(lat_hit), 32'h1);
    check("badpar_keys", 32'(keys), 32'b0010);
    send_bits(8'h1A, 1'b0, 1'b0, 11);
    check("badstop_err_cnt", 32'(ne - e0), 32'd2);
    check("bad_valid_cnt", 32'(nv - v0), 32'd0);
    check("bad_scan_code", 32'(scan_code), 32'h1A);
    send(8'h1A);
    check("shoot_keys", 32'(keys), 32'b1010);
    // Error clears pending prefixes: plain 74 afterwards is not a right release.
    send(8'hE0);
    send(8'hF0);
    send_bits(8'h55, 1'b1, 1'b1, 11);
    send(8'h74);
    check("err_clears_flags", 32'(keys), 32'b1010);
    check("err_clears_err_cnt", 32'(ne - e0), 32'd3);

    // Reset mid-frame: partial frame vanishes without an error.
    e0 = ne;
    send_bits(8'h12, 1'b0, 1'b1, 5);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("midrst_keys", 32'(keys), 32'h0);
    repeat (100) @(negedge clk);
    send(8'h1A);
    check("midrst_shoot_keys", 32'(keys), 32'b1000);
    check("midrst_err_cnt", 32'(ne - e0), 32'd0);
    check("midrst_scan_code", 32'(scan_code), 32'h1A);

`ifdef PS2_WATCHDOG_EN
    // Abandoned frame: error arrives roughly TIMEOUT_CYCLES after the last edge.
    e0 = ne;
    send_bits(8'h12, 1'b0, 1'b1, 5);
    check("wd_no_early_err", 32'(ne - e0), 32'd0);
    repeat (40) @(negedge clk);
    check("wd_err_cnt", 32'(ne - e0), 32'd1);
    send(8'hE0);
    send(8'h74);
    check("wd_recover_keys", 32'(keys), 32'b1010);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ps2_keys.md
# ps2_keys

Receives PS/2 keyboard frames and converts them into the four held-key levels that the `kid` block consumes on its `keys` input. The block samples the raw `ps2_clk` and `ps2_data` pins on the system clock, validates each 11-bit frame, and tracks the E0 and F0 prefix bytes. It keeps one level per game key, updated on every make or break code. It sits between the board PS/2 pins and the game logic (`kid`, restart/shoot handling).

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of the pin synchronizers; minimum 2.
- `TIMEOUT_CYCLES`, default 100000: idle `clk` cycles allowed between `ps2_clk` falling edges inside a frame; used only when the watchdog is compiled in.
- `clk` in 1: system clock. Single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `keys` out 4: held levels, active-high. Bit 0 = left (E0 6B), bit 1 = right (E0 74), bit 2 = jump (Left Shift, 12), bit 3 = shoot (Z, 1A).
- `scan_code` out 8: last correctly received byte, including prefix bytes.
- `scan_valid` out 1: one-cycle pulse when `scan_code` updates.
- `frame_err` out 1: one-cycle pulse when a frame is rejected.

## Operation
- **Synchronizers:** both pins pass through `SYNC_STAGES` flip-flops. A falling edge is the synchronized clock going from 1 in the previous cycle to 0 in the current cycle.
- **Frame FSM:** all transitions happen only on a detected falling edge.
  - IDLE: data 0 (start bit) -> DATA with bit count 0. Data 1 -> stay in IDLE, no error.
  - DATA: shift data in LSB first. After 8 bits -> PARITY.
  - PARITY: latch the parity bit -> STOP.
  - STOP: go to IDLE. The frame is good when data = 1 and the 9 bits (data + parity) have odd parity; otherwise it is an error.
- **Good frame:** `scan_code` <= byte; `scan_valid` pulses.
- **Bad frame:** byte discarded; `frame_err` pulses; ext and brk flags cleared; `keys` unchanged.
- **Prefix decode,** on each good byte:
  - E0 sets the ext flag.
  - F0 sets the brk flag. The two prefixes are accepted in either order.
  - Any other byte is looked up as the pair (ext, code). On a match, `keys[idx]` <= ~brk. Matched or not, both flags are then cleared.
- **Typematic repeat:** repeated make codes leave the key at 1.
- **Stray break:** a break for a key that is not held is a no-op.
- **Multiple keys:** any combination of the four keys may be held at once. Each bit is independent.
- **Ext flag matters:** a non-extended 6B (keypad 4) does not touch `keys[0]`.

## Timing
- **Reset values:** every output and internal register goes to 0. The FSM goes to IDLE and the synchronizers fill with 1 (idle line), so reset does not create a false falling edge.
- **Reset mid-frame:** the partial frame is dropped with no `frame_err`. Reception restarts at the next start bit.
- **Latency:** `scan_valid`, `frame_err` and the `keys` update are registered together. They appear SYNC_STAGES+1 cycles after the pin-level falling edge of the stop bit.
- `scan_code` holds its value until the next good frame.
- There is no backpressure; the consumer samples levels.

## Configuration
- **`PS2_WATCHDOG_EN` defined:**
  - A counter restarts on every detected falling edge.
  - In any state other than IDLE, reaching TIMEOUT_CYCLES-1 idle cycles sends the FSM to IDLE, pulses `frame_err` and clears both flags.
  - In IDLE the counter is frozen.
- **Undefined:** no counter is built. The FSM waits indefinitely for the remaining bits.

## Structure
- **Package `ps2_pkg`:** FSM state enum (IDLE, DATA, PARITY, STOP), prefix constants E0 and F0, the four scan-code constants, and the key-index constants KEY_LEFT=0, KEY_RIGHT=1, KEY_JUMP=2, KEY_SHOOT=3.
- **Sub-module `ps2_frame_rx`:** synchronizers, edge detect, frame FSM, parity check and the watchdog. Outputs are a byte, a valid pulse and an error pulse.
- **Top `ps2_keys`:** the prefix flags, the lookup and the `keys` register.

## Test plan
- Reset release, pins idle high for 1000 cycles -> `keys` = 0000, no `scan_valid`, no `frame_err`.
- Send 12 -> `keys` = 0100. Send E0 74 -> `keys` = 0110. Send F0 12 -> `keys` = 0010. Each byte gives exactly one `scan_valid` pulse.
- Send E0 6B three times (typematic), then E0 F0 6B -> bit 0 goes 1 and stays 1, then returns to 0. Send non-extended 6B -> `keys` unchanged.
- Send 1A with a wrong parity bit, then 1A with a stop bit of 0 -> two `frame_err` pulses, `keys[3]` stays 0, `scan_code` unchanged. A following good 1A gives `keys[3]` = 1.
- Assert `rst_n` low after 4 data bits of 12, then send a full 1A -> no error, `keys` = 1000.
- With `PS2_WATCHDOG_EN` and `TIMEOUT_CYCLES` = 50: stop toggling `ps2_clk` after 5 bits -> `frame_err` pulses 50 cycles later and the next clean frame decodes correctly.
